pending_request_encoder: RTL and testbench

- Inverse of the POKEY-side one-hot address decode: collects 2**width one-hot request/status lines into a sticky pending register and presents the highest-priority unmasked pending line as a binary index.
- Consumer takes requests with a valid/ack handshake; the acknowledged bit is cleared.
- Sits between POKEY event sources (timer underflow, serial, keyboard) and the CPU IRQ/status read path.

---
 rtl/pending_request_encoder.sv | 68 ++++++
 tb/tb_pending_request_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pending_request_encoder.sv
// Sticky pending-request collector with a lowest-index-first priority encoder.
// Event sources set pending bits; the consumer drains them one index at a time.
module pending_request_encoder #(
    parameter int width = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [(1<<width)-1:0] req_in,
    input  logic [(1<<width)-1:0] mask,
    input  logic                  ack,
    input  logic                  clear_all,
    output logic [(1<<width)-1:0] pending,
    output logic                  valid,
    output logic [width-1:0]      index
);

    localparam int N = 1 << width;

    // Handshake: index is offered while valid=1. The offer is taken when
    // ack=1 and valid=1 on an enabled edge; ack at any other time is ignored.

    logic [N-1:0]     pending_q, pending_d;
    logic             valid_q, valid_d;
    logic [width-1:0] index_q, index_d;
    logic [N-1:0]     clr;
    logic [N-1:0]     eligible;

    always_comb begin
        clr       = '0;
        pending_d = '0;
        eligible  = '0;
        valid_d   = 1'b0;
        index_d   = '0;

        if (ack && valid_q) begin
            clr[index_q] = 1'b1;
        end
        // Set is OR-ed after the clear, so a re-arriving request survives its ack.
        pending_d = clear_all ? '0 : ((pending_q & ~clr) | req_in);
        eligible  = pending_d & ~mask;
        valid_d   = |eligible;

        // Scan high to low so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                index_d = width'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
        end else if (enable) begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
        end
    end

    assign pending = pending_q;
    assign valid   = valid_q;
    assign index   = index_q;

endmodule

// File: tb/tb_pending_request_encoder.sv
// Directed bench for pending_request_encoder at width=3 (eight request lines).
module tb_pending_request_encoder;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       ack;
  logic       clear_all;
  logic [7:0] pending;
  logic       valid;
  logic [2:0] index;

  int checks;
  int errors;

  pending_request_encoder #(.width(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_in    (req_in),
    .mask      (mask),
    .ack       (ack),
    .clear_all (clear_all),
    .pending   (pending),
    .valid     (valid),
    .index     (index)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req_in = '0; mask = '0; ack = 1'b0; clear_all = 1'b0;
    tick();
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0 || index !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got p=%h v=%b i=%0d exp p=00 v=0 i=0", pending, valid, index);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_in = 8'h20; tick(); req_in = 8'h00;
    checks++;
    if (pending !== 8'h20 || valid !== 1'b1 || index !== 3'd5) begin
      errors++;
      $display("FAIL single_present got p=%h v=%b i=%0d exp p=20 v=1 i=5", pending, valid, index);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack got p=%h v=%b exp p=00 v=0", pending, valid);
    end
  endtask

  task automatic test_priority();
    req_in = 8'h44; tick(); req_in = 8'h00;
    checks++;
    if (pending !== 8'h44 || valid !== 1'b1 || index !== 3'd2) begin
      errors++;
      $display("FAIL prio_first got p=%h v=%b i=%0d exp p=44 v=1 i=2", pending, valid, index);
    end
    ack = 1'b1; tick();
    checks++;
    if (pending !== 8'h40 || valid !== 1'b1 || index !== 3'd6) begin
      errors++;
      $display("FAIL prio_second got p=%h v=%b i=%0d exp p=40 v=1 i=6", pending, valid, index);
    end
    tick(); ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_drained got p=%h v=%b exp p=00 v=0", pending, valid);
    end
  endtask

  task automatic test_set_beats_clear();
    req_in = 8'h08; tick();
    checks++;
    if (index !== 3'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL sbc_present got v=%b i=%0d exp v=1 i=3", valid, index);
    end
    ack = 1'b1; req_in = 8'h08; tick(); req_in = 8'h00;
    checks++;
    if (pending !== 8'h08 || valid !== 1'b1 || index !== 3'd3) begin
      errors++;
      $display("FAIL sbc_kept got p=%h v=%b i=%0d exp p=08 v=1 i=3", pending, valid, index);
    end
    tick(); ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL sbc_drain got p=%h v=%b exp p=00 v=0", pending, valid);
    end
  endtask

  task automatic test_back_to_back();
    // Repeated requests on one line collapse into a single pending bit.
    req_in = 8'h01; tick(); tick(); req_in = 8'h00;
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL collapse got p=%h v=%b exp p=00 v=0", pending, valid);
    end
    // ack while idle must not disturb a request that lands the same edge.
    ack = 1'b1; req_in = 8'h80; tick(); ack = 1'b0; req_in = 8'h00;
    checks++;
    if (pending !== 8'h80 || valid !== 1'b1 || index !== 3'd7) begin
      errors++;
      $display("FAIL idle_ack got p=%h v=%b i=%0d exp p=80 v=1 i=7", pending, valid, index);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_mask_clear_all();
    req_in = 8'h03; mask = 8'h01; tick(); req_in = 8'h00;
    checks++;
    if (pending !== 8'h03 || valid !== 1'b1 || index !== 3'd1) begin
      errors++;
      $display("FAIL mask_one got p=%h v=%b i=%0d exp p=03 v=1 i=1", pending, valid, index);
    end
    mask = 8'h03; tick();
    checks++;
    if (pending !== 8'h03 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mask_all got p=%h v=%b exp p=03 v=0", pending, valid);
    end
    mask = 8'h00; tick();
    checks++;
    if (valid !== 1'b1 || index !== 3'd0) begin
      errors++;
      $display("FAIL unmask got v=%b i=%0d exp v=1 i=0", valid, index);
    end
    clear_all = 1'b1; req_in = 8'h80; ack = 1'b1; tick();
    clear_all = 1'b0; req_in = 8'h00; ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_all got p=%h v=%b exp p=00 v=0", pending, valid);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0; req_in = 8'hFF; ack = 1'b1; tick();
    req_in = 8'h00; ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0 || index !== 3'd0) begin
      errors++;
      $display("FAIL en_off got p=%h v=%b i=%0d exp p=00 v=0 i=0", pending, valid, index);
    end
    enable = 1'b1; req_in = 8'h10; tick(); req_in = 8'h00;
    checks++;
    if (pending !== 8'h10 || valid !== 1'b1 || index !== 3'd4) begin
      errors++;
      $display("FAIL en_on got p=%h v=%b i=%0d exp p=10 v=1 i=4", pending, valid, index);
    end
    enable = 1'b0; ack = 1'b1; tick();
    checks++;
    if (pending !== 8'h10 || valid !== 1'b1 || index !== 3'd4) begin
      errors++;
      $display("FAIL en_ack_held got p=%h v=%b i=%0d exp p=10 v=1 i=4", pending, valid, index);
    end
    enable = 1'b1; tick(); ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL en_ack_taken got p=%h v=%b exp p=00 v=0", pending, valid);
    end
  endtask

  task automatic test_reset_mid();
    req_in = 8'h24; tick(); req_in = 8'h00;
    checks++;
    if (pending !== 8'h24 || valid !== 1'b1 || index !== 3'd2) begin
      errors++;
      $display("FAIL rmid_setup got p=%h v=%b i=%0d exp p=24 v=1 i=2", pending, valid, index);
    end
    ack = 1'b1; reset = 1'b1; #1;
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0 || index !== 3'd0) begin
      errors++;
      $display("FAIL rmid_async got p=%h v=%b i=%0d exp p=00 v=0 i=0", pending, valid, index);
    end
    req_in = 8'hFF; tick();
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0 || index !== 3'd0) begin
      errors++;
      $display("FAIL rmid_hold got p=%h v=%b i=%0d exp p=00 v=0 i=0", pending, valid, index);
    end
    req_in = 8'h00; ack = 1'b0; reset = 1'b0; tick();
    checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release got p=%h v=%b exp p=00 v=0", pending, valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_priority();
    test_set_beats_clear();
    test_back_to_back();
    test_mask_clear_all();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
